// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared switch word/port definitions
package switch_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] port_id_t;

  localparam port_id_t PORT_DEFAULT = 2'b00;
  localparam port_id_t PORT1        = 2'b01;
  localparam port_id_t PORT2        = 2'b10;
  localparam port_id_t PORT3        = 2'b11;
  // Words tagged PORT_DEFAULT are steered to this port by the scheduler.
  localparam port_id_t DEFAULT_ROUTE = PORT2;

  localparam logic [WORD_W-1:0] IDLE_WORD = '0;

endpackage

// File: rtl/ingress_ram.sv
// rtl/ingress_ram.sv - queue storage, one write port, asynchronous read
module ingress_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ingress_queue.sv
// rtl/ingress_queue.sv - per-port ingress queue, show-ahead head word to scheduler
// Idle (all-zero) line words are dropped and counted instead of queued.
module ingress_queue
  import switch_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rdreq,
  output logic [WIDTH-1:0] data,
  output logic [AW-1:0]    usedw,
  output logic             full,
  output logic             empty,
  output logic [15:0]      idle_cnt,
  output logic             underflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head;
  logic             accept;
  logic             wr;
  logic             idle;
  logic             pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;

  assign accept = in_valid && in_ready;
  assign wr     = accept && (in_data != WIDTH'(IDLE_WORD));
  assign idle   = accept && (in_data == WIDTH'(IDLE_WORD));
  assign pop    = rdreq && !empty;

  // count only exceeds 2^AW-1 when it equals DEPTH, so the top bit flags saturation.
  assign usedw = count[AW] ? '1 : count[AW-1:0];
  assign data  = empty ? '0 : head;

  ingress_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      idle_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (idle && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
      if (rdreq && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: doc/ingress_queue.md
# ingress_queue

Per-input-port packet-word queue that sits between a line-side source and the switch scheduler, one instance per input port. It accepts words from the line with a valid/ready handshake and discards idle (all-zero) words. Queued words are presented show-ahead to the scheduler as `data` with an occupancy indication `usedw`, and the head word is popped on the scheduler's `rdreq` pulse. It is the responder end of the scheduler's `data`/`usedw`/`rdreq` interface.

## Interface
- `WIDTH`, 32: word width; bits [1:0] carry the destination port id.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `AW`, $clog2(DEPTH): `usedw` width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  WIDTH  line-side word.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  queue can accept a word.
- `rdreq`  in  1  scheduler pop request for the head word.
- `data`  out  WIDTH  head word, show-ahead; 0 when empty.
- `usedw`  out  AW  occupancy, saturated at 2^AW−1; nonzero iff not empty.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `idle_cnt`  out  16  number of discarded all-zero words, saturating.
- `underflow`  out  1  sticky: `rdreq` seen while empty.

## Operation
- Internal count is AW+1 bits, range 0..DEPTH. Write and read pointers are AW bits and wrap modulo DEPTH.
- `in_ready = !full`, registered-state only; there is no combinational path from `rdreq`.
- Accept occurs when `in_valid && in_ready`.
  - If `in_data != 0`: write at wptr, wptr+1.
  - If `in_data == 0`: discard the word, `idle_cnt` += 1 with saturation at 16'hFFFF, and leave the queue unchanged.
- Pop occurs when `rdreq && !empty`: rptr+1.
- `rdreq && empty`: no pop; set `underflow` to 1. It stays set until reset.
- Count update per cycle: +1 on a non-idle accept only, −1 on a pop only, unchanged when both or neither occur.
- Same cycle write+pop:
  - Nonempty and not full: both occur and count is unchanged.
  - Full: `in_ready` = 0, so only the pop occurs.
  - Empty: the write occurs and the pop is ignored, with `underflow` set.
- `data` = mem[rptr] when !empty, else all zero. The scheduler treats zero as "no request", so an empty queue never issues a request.
- `usedw` = min(count, 2^AW−1).
- Storage contents carry no reset. Only the pointers, count and flags reset.

## Timing
- Reset values: `in_ready`=1, `data`=0, `usedw`=0, `full`=0, `empty`=1, `idle_cnt`=0, `underflow`=0. Pointers and count are 0.
- Reset assertion mid-operation empties the queue immediately (asynchronous). Released state matches the reset values. Queued words are lost.
- Write-to-head latency is 1 cycle: a word accepted at edge n appears on `data` after edge n if the queue was empty.
- Pop-to-next latency is 1 cycle: after the edge that sampled `rdreq`, `data` shows the next word, or 0 if the queue is now empty.
- `rdreq` is a single-cycle pulse per pop. A `rdreq` held for k cycles pops up to k words.
- `full`, `empty` and `usedw` are registered, or derived combinationally from registered count only. They change only at clock edges or on reset.
- Throughput: one accept and one pop per cycle sustained.

## Structure
- Shared package `switch_pkg`:
  - `WORD_W` = 32.
  - `typedef logic [1:0] port_id_t`.
  - Constants PORT1=2'b01, PORT2=2'b10, PORT3=2'b11, PORT_DEFAULT=2'b00. PORT_DEFAULT routes to PORT2.
  - `IDLE_WORD` = '0.
- One sub-module, `ingress_ram`: DEPTH×WIDTH, one write port, asynchronous read at rptr, no reset.
- Pointer/count/flag logic stays in `ingress_queue`.

## Test plan
1. Reset release, then write 32'h0000_0011 (single accept) → 1 cycle later `data`=32'h11, `usedw`=1, `empty`=0. Pulse `rdreq` → next cycle `data`=0, `usedw`=0, `empty`=1.
2. Fill with 32'hA1, 32'hA2, 32'hA3, 32'hA4 → `full`=1, `in_ready`=0, `usedw`=3. Hold `in_valid` with 32'hA5 for 2 cycles → not accepted. Pop 4 times → `data` sequence A1,A2,A3,A4 then 0.
3. Count at 2, with `rdreq` and a valid 32'hB2 in the same cycle → count stays 2. Order is preserved across a pointer wrap after 6 such cycles.
4. Empty queue, `rdreq`=1 together with `in_data`=32'hC3 → word queued, `data`=32'hC3 next cycle, `underflow`=1 and stays 1.
5. Three accepted zero words interleaved with 32'hD1 → only D1 is queued, `idle_cnt`=3. Preload `idle_cnt` near saturation, then more zero words → `idle_cnt` holds 16'hFFFF.
6. Assert `rst_n`=0 asynchronously mid-cycle with 3 words queued → outputs take reset values immediately without a clock edge. After release, the first new word appears as the head.
